// File: rtl/video_timing_gen.sv
// Runtime-programmable video timing generator: h/v counters, registered HS/VS/DE/RGB,
// frame/line strobes, and a pending timing set that is swapped in only at the frame wrap.
module video_timing_gen #(
    parameter int CW        = 11,
    parameter int COLW      = 8,
    parameter int DEF_HACT  = 800,
    parameter int DEF_HFP   = 24,
    parameter int DEF_HSYNC = 40,
    parameter int DEF_HTOT  = 896,
    parameter int DEF_VACT  = 600,
    parameter int DEF_VFP   = 4,
    parameter int DEF_VSYNC = 3,
    parameter int DEF_VTOT  = 625,
    parameter bit DEF_HPOL  = 1'b1,
    parameter bit DEF_VPOL  = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            ce,
    input  logic            cfg_load,
    input  logic [CW-1:0]   cfg_hact,
    input  logic [CW-1:0]   cfg_hfp,
    input  logic [CW-1:0]   cfg_hsync,
    input  logic [CW-1:0]   cfg_htot,
    input  logic [CW-1:0]   cfg_vact,
    input  logic [CW-1:0]   cfg_vfp,
    input  logic [CW-1:0]   cfg_vsync,
    input  logic [CW-1:0]   cfg_vtot,
    input  logic            cfg_hpol,
    input  logic            cfg_vpol,
    output logic            cfg_pending,
    output logic            cfg_err,
    input  logic [COLW-1:0] rin,
    input  logic [COLW-1:0] gin,
    input  logic [COLW-1:0] bin,
    output logic [COLW-1:0] rout,
    output logic [COLW-1:0] gout,
    output logic [COLW-1:0] bout,
    output logic            hs,
    output logic            vs,
    output logic            de,
    output logic            frame_start,
    output logic            line_start,
    output logic [CW-1:0]   hc,
    output logic [CW-1:0]   vc
);

    typedef struct packed {
        logic [CW-1:0] hact, hfp, hsync, htot;
        logic [CW-1:0] vact, vfp, vsync, vtot;
        logic          hpol, vpol;
    } timing_t;

    localparam timing_t DEF_T = '{
        hact: CW'(DEF_HACT), hfp: CW'(DEF_HFP), hsync: CW'(DEF_HSYNC), htot: CW'(DEF_HTOT),
        vact: CW'(DEF_VACT), vfp: CW'(DEF_VFP), vsync: CW'(DEF_VSYNC), vtot: CW'(DEF_VTOT),
        hpol: DEF_HPOL, vpol: DEF_VPOL
    };

    logic [CW-1:0]   hc_q, hc_d, vc_q, vc_d;
    timing_t         act_q, act_d, pend_q, pend_d, cfg_in;
    logic            pflag_q, pflag_d, err_q, err_d;
    logic            hs_q, hs_d, vs_q, vs_d, de_q, de_d, ls_q, ls_d, fs_q, fs_d;
    logic [COLW-1:0] r_q, r_d, g_q, g_d, b_q, b_d;

    logic            cfg_ok, h_last, v_last, in_hs, in_vs;
    logic [CW+1:0]   h_beg, h_end, v_beg, v_end;

    always_comb begin
        cfg_in = '{
            hact: cfg_hact, hfp: cfg_hfp, hsync: cfg_hsync, htot: cfg_htot,
            vact: cfg_vact, vfp: cfg_vfp, vsync: cfg_vsync, vtot: cfg_vtot,
            hpol: cfg_hpol, vpol: cfg_vpol
        };
        cfg_ok = (cfg_htot >= CW'(2)) && (cfg_vtot >= CW'(2)) &&
                 (cfg_hact <= cfg_htot) && (cfg_vact <= cfg_vtot);
        h_last = (hc_q == act_q.htot - CW'(1));
        v_last = (vc_q == act_q.vtot - CW'(1));

        // Widened sums so a sync window reaching past the total never wraps.
        h_beg = {2'b00, act_q.hact} + {2'b00, act_q.hfp};
        h_end = h_beg + {2'b00, act_q.hsync};
        v_beg = {2'b00, act_q.vact} + {2'b00, act_q.vfp};
        v_end = v_beg + {2'b00, act_q.vsync};
        in_hs = ({2'b00, hc_q} >= h_beg) && ({2'b00, hc_q} < h_end);
        in_vs = ({2'b00, vc_q} >= v_beg) && ({2'b00, vc_q} < v_end);
    end

    always_comb begin
        hc_d    = hc_q;
        vc_d    = vc_q;
        act_d   = act_q;
        pend_d  = pend_q;
        pflag_d = pflag_q;
        err_d   = err_q;
        hs_d    = hs_q;
        vs_d    = vs_q;
        de_d    = de_q;
        r_d     = r_q;
        g_d     = g_q;
        b_d     = b_q;
        ls_d    = 1'b0;
        fs_d    = 1'b0;

        if (ce) begin
            de_d = (hc_q < act_q.hact) && (vc_q < act_q.vact);
            hs_d = in_hs ? act_q.hpol : ~act_q.hpol;
            vs_d = in_vs ? act_q.vpol : ~act_q.vpol;
            r_d  = de_d ? rin : '0;
            g_d  = de_d ? gin : '0;
            b_d  = de_d ? bin : '0;
            ls_d = (hc_q == '0);
            fs_d = (hc_q == '0) && (vc_q == '0);

            if (h_last) begin
                hc_d = '0;
                vc_d = v_last ? '0 : vc_q + CW'(1);
                // Swapping only at the frame wrap keeps the counters inside the new totals.
                if (v_last && pflag_q) begin
                    act_d   = pend_q;
                    pflag_d = 1'b0;
                end
            end else begin
                hc_d = hc_q + CW'(1);
            end
        end

        // Evaluated after the apply so a coincident load lands in pending for the next frame.
        if (cfg_load) begin
            if (cfg_ok) begin
                pend_d  = cfg_in;
                pflag_d = 1'b1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hc_q    <= '0;
            vc_q    <= '0;
            act_q   <= DEF_T;
            pend_q  <= '0;
            pflag_q <= 1'b0;
            err_q   <= 1'b0;
            hs_q    <= ~DEF_HPOL;
            vs_q    <= ~DEF_VPOL;
            de_q    <= 1'b0;
            r_q     <= '0;
            g_q     <= '0;
            b_q     <= '0;
            ls_q    <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            hc_q    <= hc_d;
            vc_q    <= vc_d;
            act_q   <= act_d;
            pend_q  <= pend_d;
            pflag_q <= pflag_d;
            err_q   <= err_d;
            hs_q    <= hs_d;
            vs_q    <= vs_d;
            de_q    <= de_d;
            r_q     <= r_d;
            g_q     <= g_d;
            b_q     <= b_d;
            ls_q    <= ls_d;
            fs_q    <= fs_d;
        end
    end

    assign hc          = hc_q;
    assign vc          = vc_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign de          = de_q;
    assign rout        = r_q;
    assign gout        = g_q;
    assign bout        = b_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign cfg_pending = pflag_q;
    assign cfg_err     = err_q;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: reference model tracks the pixel index within the frame and
// derives every expected output arithmetically; reduced default mode keeps frames short.
module tb_video_timing_gen;
    localparam int CW = 11, COLW = 8;
    localparam int DH = 20, DHF = 3, DHS = 4, DHT = 30;
    localparam int DV = 8,  DVF = 2, DVS = 2, DVT = 12;
    localparam int GW = 2*CW + 3 + 3*COLW + 4;

    typedef struct {
        int hact, hfp, hsync, htot, vact, vfp, vsync, vtot;
        bit hpol, vpol;
    } cfg_t;

    logic clk = 0, rst_n = 0, ce = 0, cfg_load = 0;
    logic [CW-1:0] cfg_hact = '0, cfg_hfp = '0, cfg_hsync = '0, cfg_htot = '0;
    logic [CW-1:0] cfg_vact = '0, cfg_vfp = '0, cfg_vsync = '0, cfg_vtot = '0;
    logic cfg_hpol = 0, cfg_vpol = 0, cfg_pending, cfg_err;
    logic [COLW-1:0] rin = '0, gin = '0, bin = '0, rout, gout, bout;
    logic hs, vs, de, frame_start, line_start;
    logic [CW-1:0] hc, vc;
    logic [GW-1:0] got;

    video_timing_gen #(
        .CW(CW), .COLW(COLW),
        .DEF_HACT(DH), .DEF_HFP(DHF), .DEF_HSYNC(DHS), .DEF_HTOT(DHT),
        .DEF_VACT(DV), .DEF_VFP(DVF), .DEF_VSYNC(DVS), .DEF_VTOT(DVT),
        .DEF_HPOL(1'b1), .DEF_VPOL(1'b1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .ce(ce), .cfg_load(cfg_load),
        .cfg_hact(cfg_hact), .cfg_hfp(cfg_hfp), .cfg_hsync(cfg_hsync), .cfg_htot(cfg_htot),
        .cfg_vact(cfg_vact), .cfg_vfp(cfg_vfp), .cfg_vsync(cfg_vsync), .cfg_vtot(cfg_vtot),
        .cfg_hpol(cfg_hpol), .cfg_vpol(cfg_vpol), .cfg_pending(cfg_pending), .cfg_err(cfg_err),
        .rin(rin), .gin(gin), .bin(bin), .rout(rout), .gout(gout), .bout(bout),
        .hs(hs), .vs(vs), .de(de), .frame_start(frame_start), .line_start(line_start),
        .hc(hc), .vc(vc)
    );

    always #5 clk = ~clk;

    assign got = {hc, vc, hs, vs, de, rout, gout, bout, line_start, frame_start, cfg_pending, cfg_err};

    int   checks = 0, errors = 0;
    cfg_t mact, mpend, dflt;
    bit   mpflag, merr, force_ff;
    int   mk;
    bit   e_hs, e_vs, e_de, e_ls, e_fs;
    logic [COLW-1:0] e_r, e_g, e_b;

    function automatic bit cfg_ok(cfg_t c);
        return c.htot >= 2 && c.vtot >= 2 && c.hact <= c.htot && c.vact <= c.vtot;
    endfunction

    function automatic logic [GW-1:0] expv();
        return {CW'(mk % mact.htot), CW'(mk / mact.htot), e_hs, e_vs, e_de, e_r, e_g, e_b,
                e_ls, e_fs, mpflag, merr};
    endfunction

    function automatic cfg_t rand_cfg();
        cfg_t c;
        c.htot = $urandom_range(2, 40);  c.hact = $urandom_range(0, c.htot);
        c.hfp  = $urandom_range(0, 8);   c.hsync = $urandom_range(0, 8);
        c.vtot = $urandom_range(2, 14);  c.vact = $urandom_range(0, c.vtot);
        c.vfp  = $urandom_range(0, 4);   c.vsync = $urandom_range(0, 4);
        c.hpol = 1'($urandom);           c.vpol = 1'($urandom);
        return c;
    endfunction

    task automatic model_reset();
        mact = dflt; mk = 0; mpflag = 0; merr = 0;
        e_hs = !dflt.hpol; e_vs = !dflt.vpol; e_de = 0; e_ls = 0; e_fs = 0;
        e_r = '0; e_g = '0; e_b = '0;
    endtask

    // Drive one clock of stimulus, advance the model, and return #1 after the edge.
    task automatic step(input bit c, input bit ld, input cfg_t cf);
        int h, v;
        ce = c; cfg_load = ld;
        cfg_hact = CW'(cf.hact); cfg_hfp = CW'(cf.hfp); cfg_hsync = CW'(cf.hsync); cfg_htot = CW'(cf.htot);
        cfg_vact = CW'(cf.vact); cfg_vfp = CW'(cf.vfp); cfg_vsync = CW'(cf.vsync); cfg_vtot = CW'(cf.vtot);
        cfg_hpol = cf.hpol; cfg_vpol = cf.vpol;
        rin = force_ff ? 8'hFF : 8'($urandom);
        gin = force_ff ? 8'hFF : 8'($urandom);
        bin = force_ff ? 8'hFF : 8'($urandom);
        if (c) begin
            h = mk % mact.htot; v = mk / mact.htot;
            e_de = h < mact.hact && v < mact.vact;
            e_hs = (h >= mact.hact + mact.hfp && h < mact.hact + mact.hfp + mact.hsync) ? mact.hpol : !mact.hpol;
            e_vs = (v >= mact.vact + mact.vfp && v < mact.vact + mact.vfp + mact.vsync) ? mact.vpol : !mact.vpol;
            e_r = e_de ? rin : '0; e_g = e_de ? gin : '0; e_b = e_de ? bin : '0;
            e_ls = (h == 0); e_fs = (h == 0 && v == 0);
            mk++;
            if (mk == mact.htot * mact.vtot) begin
                mk = 0;
                if (mpflag) begin mact = mpend; mpflag = 0; end
            end
        end else begin
            e_ls = 0; e_fs = 0;
        end
        if (ld) begin
            if (cfg_ok(cf)) begin mpend = cf; mpflag = 1; end
            else merr = 1;
        end
        @(posedge clk); #1;
        cfg_load = 0;
    endtask

    task automatic test_reset();
        rst_n = 0; ce = 1;
        repeat (3) @(posedge clk);
        #1;
        model_reset();
        checks++;
        if (got !== expv()) begin
            errors++; $display("FAIL reset got %h want %h", got, expv());
        end
        @(negedge clk); rst_n = 1;
        #4;
    endtask

    task automatic test_default_mode();
        int hs_on = 0, de_cnt = 0, ls_cnt = 0;
        for (int i = 1; i <= DHT * DVT + 40; i++) begin
            step(1, 0, dflt);
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL default cyc %0d got %h want %h", i, got, expv());
            end
            if (i <= DHT && hs) hs_on++;
            if (i <= DHT * DVT) begin de_cnt += de; ls_cnt += line_start; end
        end
        checks++;
        if (hs_on !== DHS) begin errors++; $display("FAIL hs_width got %0d want %0d", hs_on, DHS); end
        checks++;
        if (de_cnt !== DH * DV) begin errors++; $display("FAIL de_count got %0d want %0d", de_cnt, DH * DV); end
        checks++;
        if (ls_cnt !== DVT) begin errors++; $display("FAIL line_count got %0d want %0d", ls_cnt, DVT); end
    endtask

    task automatic test_ce_toggle();
        int t0 = -1, t1 = -1, fs_wide = 0;
        for (int i = 0; i < 4 * DHT * DVT; i++) begin
            step(i % 2 == 0, 0, dflt);
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL ce_toggle cyc %0d got %h want %h", i, got, expv());
            end
            if (frame_start) begin
                if (t0 < 0) t0 = i; else if (t1 < 0) t1 = i;
                if (i % 2 == 1) fs_wide++;
            end
        end
        checks++;
        if (t1 - t0 !== 2 * DHT * DVT) begin
            errors++; $display("FAIL ce_period got %0d want %0d", t1 - t0, 2 * DHT * DVT);
        end
        checks++;
        if (fs_wide !== 0) begin errors++; $display("FAIL fs_width got %0d want 0", fs_wide); end
        for (int i = 0; i < 500; i++) begin
            step(1'($urandom), 0, dflt);
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL ce_random cyc %0d got %h want %h", i, got, expv());
            end
        end
    endtask

    task automatic test_mode_switch();
        cfg_t b = '{16, 2, 5, 22, 6, 1, 2, 9, 1'b0, 1'b0};
        int n;
        step(1, 1, b);
        checks++;
        if (cfg_pending !== 1'b1) begin errors++; $display("FAIL pend_set got %b want 1", cfg_pending); end
        n = 0;
        while (mpflag && n < 2000) begin
            step(1, 0, b); n++;
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL switch_wait cyc %0d got %h want %h", n, got, expv());
            end
        end
        checks++;
        if (mpflag || hc !== 0 || vc !== 0) begin
            errors++; $display("FAIL switch_wrap got hc %0d vc %0d pend %b want 0 0 0", hc, vc, cfg_pending);
        end
        for (int i = 0; i < 2 * 22 * 9 + 5; i++) begin
            step(1, 0, b);
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL switch_new cyc %0d got %h want %h", i, got, expv());
            end
        end
    endtask

    task automatic test_reject_and_overwrite();
        cfg_t bad = '{31, 2, 2, 30, 4, 1, 1, 10, 1'b1, 1'b1};
        cfg_t c1, c2;
        int n;
        step(1, 1, bad);
        checks++;
        if (cfg_err !== 1'b1 || cfg_pending !== 1'b0) begin
            errors++; $display("FAIL reject got err %b pend %b want 1 0", cfg_err, cfg_pending);
        end
        bad.hact = 1; bad.htot = 1; step(1, 1, bad);
        bad.htot = 30; bad.vtot = 1; step(1, 1, bad);
        bad.vtot = 4; bad.vact = 5; step(1, 1, bad);
        checks++;
        if (got !== expv()) begin errors++; $display("FAIL reject_more got %h want %h", got, expv()); end
        for (int r = 0; r < 4; r++) begin
            c1 = rand_cfg(); c2 = rand_cfg();
            step(1, 1, c1);
            repeat ($urandom_range(1, 30)) step(1, 0, c1);
            step(1, 1, c2);
            n = 0;
            while (n < 3 * 600) begin
                step(1, 0, c2); n++;
                checks++;
                if (got !== expv()) begin
                    errors++; if (errors <= 20) $display("FAIL overwrite r%0d cyc %0d got %h want %h", r, n, got, expv());
                end
                if (!mpflag && mk == 0) break;
            end
            if (n >= 3 * 600) begin errors++; $display("FAIL overwrite_timeout r%0d", r); end
        end
    endtask

    task automatic test_coincident_load();
        cfg_t c1 = rand_cfg(), c2 = rand_cfg();
        int n = 0;
        step(1, 1, c1);
        while (mk != mact.htot * mact.vtot - 1 && n < 2000) begin step(1, 0, c1); n++; end
        checks++;
        if (n >= 2000) begin errors++; $display("FAIL coincident_timeout"); end
        step(1, 1, c2);
        checks++;
        if (got !== expv()) begin errors++; $display("FAIL coincident got %h want %h", got, expv()); end
        for (int i = 0; i < 1300; i++) begin
            step(1, 0, c2);
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL coincident_run cyc %0d got %h want %h", i, got, expv());
            end
        end
    endtask

    task automatic test_rgb_ff();
        int bad = 0;
        force_ff = 1;
        for (int i = 0; i < 700; i++) begin
            step(1, 0, dflt);
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL rgb_ff cyc %0d got %h want %h", i, got, expv());
            end
            if ({rout, gout, bout} !== (de ? 24'hFFFFFF : 24'h0)) bad++;
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL rgb_blank got %0d bad cycles want 0", bad); end
        force_ff = 0;
    endtask

    task automatic test_async_reset();
        cfg_t c = rand_cfg();
        step(1, 1, c);
        repeat (7) step(1, 0, c);
        #2 rst_n = 0;
        #1;
        model_reset();
        checks++;
        if (got !== expv()) begin errors++; $display("FAIL async_reset got %h want %h", got, expv()); end
        @(negedge clk); rst_n = 1;
        #4;
        for (int i = 0; i < 2 * DHT * DVT; i++) begin
            step(1, 0, c);
            checks++;
            if (got !== expv()) begin
                errors++; if (errors <= 20) $display("FAIL after_reset cyc %0d got %h want %h", i, got, expv());
            end
        end
    endtask

    initial begin
        dflt = '{DH, DHF, DHS, DHT, DV, DVF, DVS, DVT, 1'b1, 1'b1};
        force_ff = 0;
        test_reset();
        test_default_mode();
        test_ce_toggle();
        test_mode_switch();
        test_rgb_ff();
        test_coincident_load();
        test_async_reset();
        test_reject_and_overwrite();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
